// File: rtl/sram_pio_pkg.sv
// Shared register map constants for the sram_input_pio slave.
package sram_pio_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP  = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RISE_EN   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_FALL_EN   = 3'd5;

endpackage

// File: rtl/sram_pio_debounce.sv
// One input channel: 2-flop synchroniser followed by an optional stability counter.
// The counter exists only when SRAM_INPUT_PIO_DEBOUNCE_EN is defined.
module sram_pio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   logic sync_meta;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
      end
   end

`ifdef SRAM_INPUT_PIO_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             level_q;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles; count stops at CNT_MAX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         level_q <= 1'b0;
      end else if (sync_q == level_q) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         level_q <= sync_q;
         cnt     <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign level = level_q;
`else
   localparam int unsigned unused_cycles = DEBOUNCE_CYCLES;

   assign level = sync_q;
`endif

endmodule

// File: rtl/sram_input_pio.sv
// Parallel input port slave with edge capture and level interrupt.
// Define SRAM_INPUT_PIO_DEBOUNCE_EN to add per-channel debounce counters.
module sram_input_pio
   import sram_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [DATA_W-1:0] readdata,
   output logic              irq
);

   logic [WIDTH-1:0]  level;
   logic [WIDTH-1:0]  level_d;
   logic [WIDTH-1:0]  irq_mask;
   logic [WIDTH-1:0]  edge_cap;
   logic [WIDTH-1:0]  rise_en;
   logic [WIDTH-1:0]  fall_en;
   logic [WIDTH-1:0]  edge_hit;
   logic [WIDTH-1:0]  clr_mask;
   logic [WIDTH-1:0]  edge_next;
   logic [DATA_W-1:0] rd_mux;
   logic              wr;
   logic              unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sram_pio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (in_port[i]),
         .level (level[i])
      );
   end

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   // New edges win over a same-cycle clear of the same bit.
   always_comb begin
      edge_hit  = (level & ~level_d & rise_en) | (~level & level_d & fall_en);
      clr_mask  = (wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;
      edge_next = (edge_cap & ~clr_mask) | edge_hit;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:     rd_mux = DATA_W'(level);
         ADDR_IRQ_MASK: rd_mux = DATA_W'(irq_mask);
         ADDR_EDGE_CAP: rd_mux = DATA_W'(edge_cap);
         ADDR_RISE_EN:  rd_mux = DATA_W'(rise_en);
         ADDR_FALL_EN:  rd_mux = DATA_W'(fall_en);
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_d  <= '0;
         edge_cap <= '0;
         irq_mask <= '0;
         rise_en  <= '1;
         fall_en  <= '0;
         readdata <= '0;
      end else begin
         level_d  <= level;
         edge_cap <= edge_next;
         readdata <= rd_mux;
         if (wr) begin
            case (address)
               ADDR_IRQ_MASK: irq_mask <= writedata[WIDTH-1:0];
               ADDR_RISE_EN:  rise_en  <= writedata[WIDTH-1:0];
               ADDR_FALL_EN:  fall_en  <= writedata[WIDTH-1:0];
               default: ;
            endcase
         end
      end
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sram_input_pio.sv
// Scoreboard bench for sram_input_pio (WIDTH=4, DEBOUNCE_CYCLES=8), valid with or without
// SRAM_INPUT_PIO_DEBOUNCE_EN defined.
module tb_sram_input_pio;

`ifdef SRAM_INPUT_PIO_DEBOUNCE_EN
   localparam bit DEB_ON   = 1'b1;
   localparam int EDGE_LAT = 3 + 8;
`else
   localparam bit DEB_ON   = 1'b0;
   localparam int EDGE_LAT = 3;
`endif
   localparam int SETTLE = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = '0;
   logic [31:0] readdata;
   logic        irq;

   sram_input_pio #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } rd_t;

   rd_t  rd_q[$];
   rd_t  cur;
   logic rd_req = 1'b0, rd_valid = 1'b0;
   logic irq_req = 1'b0, irq_valid = 1'b0, irq_exp = 1'b0, irq_exp_q = 1'b0;
   bit   drain_req = 1'b0, drain_done = 1'b0;
   int   n_tests = 0, n_fail = 0, irq_idx = 0;

   // Requests sampled on the active edge; results compared on the following falling edge.
   always @(posedge clk) begin
      rd_valid  <= rd_req;
      irq_valid <= irq_req;
      irq_exp_q <= irq_exp;
   end

   always @(negedge clk) begin
      if (rd_valid) begin
         n_tests++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_underflow: readdata=0x%08h with no expected entry", readdata);
         end else begin
            cur = rd_q.pop_front();
            if (readdata !== cur.exp) begin
               n_fail++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, readdata, cur.exp);
            end
         end
      end
      if (irq_valid) begin
         n_tests++;
         irq_idx++;
         if (irq !== irq_exp_q) begin
            n_fail++;
            $display("FAIL irq#%0d: got %b expected %b", irq_idx, irq, irq_exp_q);
         end
      end
      if (drain_req && !drain_done) begin
         n_tests++;
         if (rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads never returned, expected 0", rd_q.size());
         end
         drain_done = 1'b1;
      end
   end

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
      rd_t t;
      t.name = nm;
      t.exp  = e;
      rd_q.push_back(t);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      rd_req     = 1'b1;
      @(negedge clk);
      rd_req     = 1'b0;
      chipselect = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic chk_irq(input logic e);
      irq_req = 1'b1;
      irq_exp = e;
      @(negedge clk);
      irq_req = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(1);

      // Reset values
      chk_irq(1'b0);
      rd(3'd4, 32'h0000_000F, "rst_rise_en");
      rd(3'd0, 32'h0, "rst_data");
      rd(3'd2, 32'h0, "rst_irq_mask");
      rd(3'd3, 32'h0, "rst_edge_cap");
      rd(3'd5, 32'h0, "rst_fall_en");
      rd(3'd1, 32'h0, "rst_unmapped1");
      rd(3'd7, 32'h0, "rst_unmapped7");

      // Short pulse on channel 0 is rejected only when debouncing
      in_port[0] = 1'b1;
      wait_cyc(5);
      in_port[0] = 1'b0;
      wait_cyc(SETTLE);
      rd(3'd0, 32'h0, "pulse_data");
      rd(3'd3, DEB_ON ? 32'h0 : 32'h1, "pulse_edge_cap");
      wr(3'd3, 32'h1);
      in_port[0] = 1'b1;
      wait_cyc(20);
      rd(3'd0, 32'h1, "hold_data");
      rd(3'd3, 32'h1, "hold_edge_cap");
      wr(3'd3, 32'h1);
      rd(3'd3, 32'h0, "clear_edge_cap");

      // Falling-only capture on channel 1
      wr(3'd5, 32'h2);
      wr(3'd4, 32'h0);
      rd(3'd4, 32'h0, "rise_en_rb");
      rd(3'd5, 32'h2, "fall_en_rb");
      in_port[1] = 1'b1;
      wait_cyc(SETTLE);
      rd(3'd3, 32'h0, "after_rise_cap");
      rd(3'd0, 32'h3, "after_rise_data");
      in_port[1] = 1'b0;
      wait_cyc(SETTLE);
      rd(3'd3, 32'h2, "after_fall_cap");
      rd(3'd0, 32'h1, "after_fall_data");
      wr(3'd3, 32'h2);

      // RW1C and irq masking
      wr(3'd4, 32'hF);
      wr(3'd5, 32'h0);
      in_port = 4'b0000;
      wait_cyc(SETTLE);
      in_port = 4'b0101;
      wait_cyc(SETTLE);
      wr(3'd2, 32'h4);
      chk_irq(1'b1);
      rd(3'd3, 32'h5, "rw1c_before");
      rd(3'd2, 32'h4, "irq_mask_rb");
      wr(3'd3, 32'h4);
      rd(3'd3, 32'h1, "rw1c_after");
      chk_irq(1'b0);

      // Clear of bit 2 lands on the same edge that captures a new channel-2 rise
      wr(3'd5, 32'h4);
      in_port[2] = 1'b0;
      wait_cyc(SETTLE);
      rd(3'd3, 32'h5, "fall2_cap");
      in_port[2] = 1'b1;
      wait_cyc(EDGE_LAT - 1);
      wr(3'd3, 32'h4);
      rd(3'd3, 32'h5, "collision_cap");
      chk_irq(1'b1);

      // Data path latency without debounce; 3-cycle pulse rejected with it
      in_port[3] = 1'b1;
      wait_cyc(2);
      rd(3'd0, DEB_ON ? 32'h5 : 32'hD, "fast_data");
      in_port[3] = 1'b0;
      wait_cyc(SETTLE);
      rd(3'd0, 32'h5, "fast_data_end");

      wait_cyc(4);
      drain_req = 1'b1;
      wait_cyc(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
